// File: rtl/apb_delayer_pkg.sv
// Shared types and helpers for the APB latency-scaling shim.
package apb_delayer_pkg;

  typedef enum logic [1:0] {StIdle, StAccess, StHold} state_t;

  // Saturating add of two values clamped to an unsigned width of w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/apb_win_match.sv
// Combinational address window decoder: hit when any masked compare matches.
module apb_win_match #(
  parameter int unsigned                ADDR_W   = 32,
  parameter int unsigned                N_WIN    = 2,
  parameter logic [N_WIN*ADDR_W-1:0]    WIN_BASE = '0,
  parameter logic [N_WIN*ADDR_W-1:0]    WIN_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o
);

  // OR-reduce the per-window masked compares.
  always_comb begin
    hit_o = 1'b0;
    for (int unsigned i = 0; i < N_WIN; i++) begin
      if ((addr_i & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_delayer_nwin.sv
// APB shim that stretches transfers hitting configured windows by R/S or a fixed delay.
module apb_delayer_nwin
  import apb_delayer_pkg::*;
#(
  parameter int unsigned             ADDR_W    = 32,
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             N_WIN     = 2,
  parameter logic [N_WIN*ADDR_W-1:0] WIN_BASE  = {32'hc000_0000, 32'ha000_0000},
  parameter logic [N_WIN*ADDR_W-1:0] WIN_MASK  = {32'hf000_0000, 32'he000_0000},
  parameter int unsigned             MODE      = 0,
  parameter int unsigned             R         = 3,
  parameter int unsigned             S         = 4,
  parameter int unsigned             FIXED_DLY = 8,
  parameter int unsigned             CNT_W     = 12
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   in_paddr,
  input  logic                in_psel,
  input  logic                in_penable,
  input  logic [2:0]          in_pprot,
  input  logic                in_pwrite,
  input  logic [DATA_W-1:0]   in_pwdata,
  input  logic [DATA_W/8-1:0] in_pstrb,
  output logic                in_pready,
  output logic [DATA_W-1:0]   in_prdata,
  output logic                in_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr,
  output logic                hold_active
);

  if (!is_pow2(S) || (R == 0) || (N_WIN == 0) || (N_WIN > 8) || (CNT_W == 0) || (CNT_W > 32))
  begin : g_bad_param
    $error("apb_delayer_nwin: S must be a power of two, R >= 1, N_WIN 1..8, CNT_W 1..32");
  end

  localparam int unsigned      LOG2S    = $clog2(S);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RSat     = CNT_W'(sat_add(32'd0, 32'(R), CNT_W));
  localparam logic [CNT_W-1:0] FixedSat = CNT_W'(sat_add(32'd0, 32'(FIXED_DLY), CNT_W));

  state_t             state_q;
  logic [CNT_W-1:0]   k_q, acc_q, cnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               slverr_q;

  logic               hit;
  logic               done;
  logic [CNT_W-1:0]   k_inc, acc_inc, scaled, extra;

  apb_win_match #(
    .ADDR_W   (ADDR_W),
    .N_WIN    (N_WIN),
    .WIN_BASE (WIN_BASE),
    .WIN_MASK (WIN_MASK)
  ) u_win_match (
    .addr_i (in_paddr),
    .hit_o  (hit)
  );

  // Downstream completes the access this cycle.
  assign done        = (state_q == StAccess) && in_psel && in_penable && out_pready;
  assign hold_active = (state_q == StHold);

  // Extra stretch computed from counters that already include the current cycle.
  always_comb begin
    k_inc   = CNT_W'(sat_add(32'(k_q), 32'd1, CNT_W));
    acc_inc = CNT_W'(sat_add(32'(acc_q), 32'(R), CNT_W));
    scaled  = acc_inc >> LOG2S;
    if (MODE == 1) extra = FixedSat;
    else           extra = (scaled > k_inc) ? (scaled - k_inc) : '0;
  end

  // Request passthrough, select masking in HOLD and response gating.
  always_comb begin
    out_paddr   = in_paddr;
    out_psel    = in_psel;
    out_penable = in_penable;
    out_pprot   = in_pprot;
    out_pwrite  = in_pwrite;
    out_pwdata  = in_pwdata;
    out_pstrb   = in_pstrb;
    in_pready   = out_pready;
    in_prdata   = out_prdata;
    in_pslverr  = out_pslverr;
    unique case (state_q)
      StIdle: ;
      StAccess: begin
        if (!(done && (extra == '0))) begin
          in_pready  = 1'b0;
          in_prdata  = '0;
          in_pslverr = 1'b0;
        end
      end
      StHold: begin
        out_psel    = 1'b0;
        out_penable = 1'b0;
        if (in_psel && (cnt_q == CntOne)) begin
          in_pready  = 1'b1;
          in_prdata  = rdata_q;
          in_pslverr = slverr_q;
        end else begin
          in_pready  = 1'b0;
          in_prdata  = '0;
          in_pslverr = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Sequencer: counts access cycles, latches the response and runs the hold countdown.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_psel && !in_penable && hit) begin
            state_q <= StAccess;
            k_q     <= CntOne;
            acc_q   <= RSat;
          end
        end
        StAccess: begin
          if (!in_psel) begin
            state_q <= StIdle;
          end else begin
            k_q   <= k_inc;
            acc_q <= acc_inc;
            if (done) begin
              if (extra == '0) begin
                state_q <= StIdle;
              end else begin
                rdata_q  <= out_prdata;
                slverr_q <= out_pslverr;
                cnt_q    <= extra;
                state_q  <= StHold;
              end
            end
          end
        end
        StHold: begin
          if (!in_psel) begin
            // Aborted by the master: drop the captured response.
            state_q  <= StIdle;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
          end else if (cnt_q == CntOne) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/apb_delayer_nwin.md
Name: apb_delayer_nwin

Overview:
- Parametrised APB latency-scaling shim between the CPU-side APB master and slow peripheral slaves.
- Scales the access latency of transfers hitting any of N configurable address windows by R/S, or by a fixed extra delay.
- Masks the downstream select while stretching, so a held transfer cannot be re-issued.
- Non-matching transfers pass through transparently with zero added latency.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; pstrb width is DATA_W/8.
- N_WIN, 2, number of delayed address windows (1..8).
- WIN_BASE, {32'hc000_0000, 32'ha000_0000}, packed N_WIN*ADDR_W base per window.
- WIN_MASK, {32'hf000_0000, 32'he000_0000}, packed N_WIN*ADDR_W compare mask per window.
- MODE, 0, 0 = ratio scaling, 1 = fixed extra delay.
- R, 3, ratio numerator (>=1).
- S, 4, ratio denominator; must be a power of two.
- FIXED_DLY, 8, extra cycles in MODE 1.
- CNT_W, 12, accumulator and counter width; saturating.

Ports:
- clock, input, 1, sole clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_paddr/in_psel/in_penable/in_pprot/in_pwrite/in_pwdata/in_pstrb, input, ADDR_W/1/1/3/1/DATA_W/DATA_W/8, upstream request.
- in_pready/in_prdata/in_pslverr, output, 1/DATA_W/1, upstream response.
- out_paddr/out_psel/out_penable/out_pprot/out_pwrite/out_pwdata/out_pstrb, output, as upstream, downstream request.
- out_pready/out_prdata/out_pslverr, input, 1/DATA_W/1, downstream response.
- hold_active, output, 1, high while in HOLD.

Behaviour:
- Window hit: OR over windows of (in_paddr & WIN_MASK[i]) == WIN_BASE[i].
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - all out_* equal in_*; in_pready/prdata/pslverr equal out_* combinationally.
  - in_psel & !in_penable & hit → ACCESS; k <= 1, acc <= R.
- ACCESS:
  - out_* pass through.
  - each cycle: k++, acc += R, both saturating at 2^CNT_W-1.
  - On in_penable & out_pready, using values including the current cycle:
    - MODE 0: extra = max(0, (acc >> log2 S) - k).
    - MODE 1: extra = FIXED_DLY.
  - extra == 0: response passes straight through this cycle → IDLE; no added latency.
  - extra > 0: latch prdata/pslverr; in_pready = 0; cnt <= extra → HOLD.
- HOLD:
  - out_psel = out_penable = 0; other out_* pass through.
  - in_pready = 0 until cnt == 1.
  - cnt == 1: in_pready = 1, in_prdata/in_pslverr = latched values for exactly one cycle → IDLE.
  - otherwise cnt--.
- Total upstream cycles (setup through ready) in MODE 0 = max(k, floor(k*R/S)).
- Response outputs are 0 whenever in_pready = 0 outside IDLE.
- Upstream drops in_psel in ACCESS or HOLD (protocol violation) → IDLE next cycle; no in_pready; latched data discarded.
- Back-to-back transfers: a new setup is accepted in the cycle after the HOLD completion.
- Reset (async, any state, mid-transfer included): state IDLE; k, acc, cnt, latched data = 0; hold_active = 0.
  - While reset_n is low, in_pready/in_prdata/in_pslverr follow out_* (IDLE passthrough).

Decomposition:
- Package apb_delayer_pkg:
  - state_t enum {IDLE, ACCESS, HOLD}.
  - localparam LOG2S = $clog2(S).
  - function sat_add(CNT_W).
  - elaboration check that S is a power of two and R >= 1.
- Sub-module apb_win_match: purely combinational window decoder (N_WIN, ADDR_W, WIN_BASE, WIN_MASK → hit).
- All sequencing stays in the top module.

Test Plan:
- MODE 0, R=3, S=1: read 0xA000_0010, slave ready on first access cycle (k=2), prdata 0x1234_5678 → extra 4; in_pready asserted cycle 6 after setup with 0x1234_5678; out_psel low during the 4 HOLD cycles.
- MODE 0, R=5, S=2: write to 0xC000_0000, slave waits 1 (k=3) → floor(15/2)=7; in_pready on cycle 7; exactly one downstream access.
- MODE 0, R=1, S=2: any hit → extra 0; timing identical to bypass. Miss address 0x8000_0000 with R=3 → zero added latency.
- MODE 1, FIXED_DLY=8: slave asserts pslverr=1 with k=2 → in_pready after 10 cycles with in_pslverr=1; hold_active high for 8 cycles.
- Assert reset_n low during HOLD with cnt=3 → immediately IDLE and hold_active=0; after release, a new hit transfer behaves as a fresh one.
- Saturation, CNT_W=4, R=3, S=1: slave waits 10 cycles → acc clamps at 15; extra = max(0, 15-k) with k clamped; no wrap-around, completion still occurs.
